// File: rtl/c64_bus_pkg.sv
// c64_bus_pkg: region, timer register offset and bit-position definitions shared by the C64 bus responder.
package c64_bus_pkg;
  typedef enum logic [2:0] {RGN_DDR, RGN_PORT, RGN_RAM, RGN_ROM, RGN_IO} region_e;
  localparam logic [3:0] TA_LO = 4'h0, TA_HI = 4'h1, TB_LO = 4'h6, TB_HI = 4'h7;
  localparam logic [3:0] ICR = 4'hD, CRA = 4'hE, CRB = 4'hF;
  localparam int CR_START = 0, CR_ONESHOT = 3, CR_FORCE_LOAD = 4;
  localparam int PORT_LORAM = 0, PORT_HIRAM = 1, PORT_CHAREN = 2;
  function automatic region_e decode(input logic [15:0] a, input logic [2:0] pe,
                                     input logic [15:0] io_base, input logic [15:0] rom_base);
    return a == 16'h0000 ? RGN_DDR :
           a == 16'h0001 ? RGN_PORT :
           (a[15:8] == io_base[15:8] && pe[PORT_CHAREN] && (pe[PORT_LORAM] || pe[PORT_HIRAM])) ? RGN_IO :
           (a >= rom_base && pe[PORT_HIRAM]) ? RGN_ROM : RGN_RAM;
  endfunction
endpackage

// File: rtl/c64_timer.sv
// c64_timer: CIA-style 16-bit countdown timer with reload latch, one-shot mode and underflow flag.
module c64_timer
  import c64_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic        wr_cr_i,
  input  logic        clr_i,
  input  logic [7:0]  wdata_i,
  output logic [15:0] count_o,
  output logic [7:0]  cr_o,
  output logic        flag_o
);
  logic [15:0] latch_q, latch_d, count_q, count_d;
  logic start_q, start_d, oneshot_q, oneshot_d, flag_q, flag_d, uflow;
  always_comb begin
    uflow = start_q && count_q == 16'h0000;
    latch_d = {wr_hi_i ? wdata_i : latch_q[15:8], wr_lo_i ? wdata_i : latch_q[7:0]};
    // Force-load and a stopped-timer high-byte write both override the running count.
    count_d = ((wr_cr_i && wdata_i[CR_FORCE_LOAD]) || (wr_hi_i && !start_q)) ? latch_d :
              !start_q ? count_q : uflow ? latch_q : count_q - 16'h0001;
    start_d = wr_cr_i ? wdata_i[CR_START] : (uflow && oneshot_q) ? 1'b0 : start_q;
    oneshot_d = wr_cr_i ? wdata_i[CR_ONESHOT] : oneshot_q;
    flag_d = uflow || (flag_q && !clr_i);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      latch_q <= 16'hFFFF;
      count_q <= 16'hFFFF;
      start_q <= 1'b0;
      oneshot_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      latch_q <= latch_d;
      count_q <= count_d;
      start_q <= start_d;
      oneshot_q <= oneshot_d;
      flag_q <= flag_d;
    end
  assign count_o = count_q;
  assign cr_o = {4'b0000, oneshot_q, 2'b00, start_q};
  assign flag_o = flag_q;
endmodule

// File: rtl/c64_bus_responder.sv
// c64_bus_responder: 6502-side RAM, processor port, KERNAL overlay and CIA-style timer responder.
// Define TIMER_B_EN to add the second timer at offsets 6/7/F with ICR bit1.
module c64_bus_responder
  import c64_bus_pkg::*;
#(
  parameter int          RAM_AW   = 16,
  parameter logic [15:0] IO_BASE  = 16'hDC00,
  parameter logic [15:0] ROM_BASE = 16'hE000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ab,
  input  logic [7:0]  do_i,
  input  logic        we,
  output logic [7:0]  di,
  output logic [12:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        irq,
  output logic [2:0]  port_eff
);
  logic [7:0] mem [2**RAM_AW];
  logic [2:0] ddr_q, port_q;
  logic [1:0] mask_q, mask_d, flag;
  logic [7:0] di_q, di_d, io_rd, rd_data, cr_a, cr_b;
  logic [15:0] cnt_a, cnt_b;
  logic rom_sel_q, io_wr, icr_rd;
  logic [3:0] off;
  region_e rgn;
  assign rom_addr = ab[12:0];
  assign port_eff = (port_q & ddr_q) | ~ddr_q;
  assign rgn = decode(ab, port_eff, IO_BASE, ROM_BASE);
  assign off = ab[3:0];
  assign io_wr = we && rgn == RGN_IO;
  assign icr_rd = !we && rgn == RGN_IO && off == ICR;
  assign irq = |(flag & mask_q);
  // ROM data arrives a cycle late, so it bypasses the data register via the registered select.
  assign di = rom_sel_q ? rom_data : di_q;
  always_comb begin
    io_rd = off == TA_LO ? cnt_a[7:0] :
            off == TA_HI ? cnt_a[15:8] :
            off == TB_LO ? cnt_b[7:0] :
            off == TB_HI ? cnt_b[15:8] :
            off == ICR   ? {irq, 5'b00000, flag} :
            off == CRA   ? cr_a :
            off == CRB   ? cr_b : 8'h00;
    rd_data = rgn == RGN_DDR  ? {5'b00000, ddr_q} :
              rgn == RGN_PORT ? {5'b00000, port_eff} :
              rgn == RGN_IO   ? io_rd : mem[ab[RAM_AW-1:0]];
    di_d = we ? di : rd_data;
    mask_d = !(io_wr && off == ICR) ? mask_q : do_i[7] ? (mask_q | do_i[1:0]) : (mask_q & ~do_i[1:0]);
  end
  c64_timer u_ta (
    .clk     (clk),
    .reset   (reset),
    .wr_lo_i (io_wr && off == TA_LO),
    .wr_hi_i (io_wr && off == TA_HI),
    .wr_cr_i (io_wr && off == CRA),
    .clr_i   (icr_rd),
    .wdata_i (do_i),
    .count_o (cnt_a),
    .cr_o    (cr_a),
    .flag_o  (flag[0])
  );
`ifdef TIMER_B_EN
  c64_timer u_tb (
    .clk     (clk),
    .reset   (reset),
    .wr_lo_i (io_wr && off == TB_LO),
    .wr_hi_i (io_wr && off == TB_HI),
    .wr_cr_i (io_wr && off == CRB),
    .clr_i   (icr_rd),
    .wdata_i (do_i),
    .count_o (cnt_b),
    .cr_o    (cr_b),
    .flag_o  (flag[1])
  );
`else
  assign cnt_b = 16'h0000;
  assign cr_b = 8'h00;
  assign flag[1] = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      di_q <= 8'h00;
      rom_sel_q <= 1'b0;
      ddr_q <= 3'b000;
      port_q <= 3'b000;
      mask_q <= 2'b00;
    end else begin
      di_q <= di_d;
      rom_sel_q <= !we && rgn == RGN_ROM;
      if (we && rgn == RGN_DDR) ddr_q <= do_i[2:0];
      if (we && rgn == RGN_PORT) port_q <= do_i[2:0];
      mask_q <= mask_d;
    end
  always_ff @(posedge clk)
    if (reset && we && (rgn == RGN_RAM || rgn == RGN_ROM)) mem[ab[RAM_AW-1:0]] <= do_i;
endmodule
